// File: rtl/fifo_read_pacer.sv
// Paces single-word reads from a FIFO and presents each word on a valid/ready port,
// optionally holding off the next read for gap_cfg_i idle cycles after each handshake.
module fifo_read_pacer #(
  parameter int DATA_WIDTH = 4,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [GAP_WIDTH-1:0]  gap_cfg_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  busy_o,
  output logic [7:0]            rd_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_HOLD,
    S_GAP
  } state_e;

  state_e                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
        rd_en_d = 1'b0;
      end
      S_CAPTURE: begin
        data_d  = fifo_data_i;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          if (gap_cfg_i == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            gap_d   = gap_cfg_i;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // Counter was loaded with gap_cfg, so leaving at 1 yields exactly gap_cfg cycles here.
        gap_d = gap_q - GAP_WIDTH'(1);
        if (gap_q == GAP_WIDTH'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_en_d = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign fifo_rd_en_o = rd_en_q;
  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign busy_o       = busy_q;
  assign rd_count_o   = cnt_q;

endmodule

// File: tb/tb_fifo_read_pacer.sv
// Bench for fifo_read_pacer: emulated FIFO, timeline reference model checked every cycle,
// delivered-word scoreboard, and directed scenarios with literal expectations.
module tb_fifo_read_pacer;
  localparam int DW = 4;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, fifo_empty, out_ready;
  logic [GW-1:0] gap_cfg;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en, out_valid, busy;
  logic [DW-1:0] out_data;
  logic [7:0]    rd_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rd_cyc[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] next_word = 4'hA;

  always #5 clk = ~clk;

  fifo_read_pacer #(.DATA_WIDTH(DW), .GAP_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .gap_cfg_i(gap_cfg),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_rd_en_o(fifo_rd_en),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .rd_count_o(rd_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Emulated FIFO: a pop presents the next word of an incrementing sequence one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en === 1'b1) begin
      fifo_data <= next_word;
      next_word <= next_word + 1'b1;
      sb.push_back(next_word);
    end
  end

  always @(posedge rst) sb.delete();

  always @(posedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("scoreboard_word_present", 0, 1);
      else chk("delivered_word", out_data, sb.pop_front());
    end
  end

  always @(negedge clk) if (fifo_rd_en === 1'b1) rd_cyc.push_back(cyc);

  // Timeline model: a transaction is its read cycle, capture one cycle later, then held
  // until accepted, then gap_cfg (sampled at acceptance) busy cycles.
  logic       m_in = 1'b0, m_acc = 1'b0;
  int         m_tstart = 0, m_tacc = 0, m_gap = 0;
  logic [DW-1:0] m_data = '0;
  logic [7:0] m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in   <= 1'b0;
      m_acc  <= 1'b0;
      m_cnt  <= '0;
      m_data <= '0;
    end else if (!m_in || (m_acc && cyc >= m_tacc + m_gap)) begin
      if (enable && !fifo_empty) begin
        m_in     <= 1'b1;
        m_acc    <= 1'b0;
        m_tstart <= cyc + 1;
      end
    end else begin
      if (cyc == m_tstart + 1) m_data <= fifo_data;
      if (!m_acc && cyc >= m_tstart + 2 && out_ready) begin
        m_acc  <= 1'b1;
        m_tacc <= cyc + 1;
        m_gap  <= int'(gap_cfg);
        m_cnt  <= m_cnt + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_rd_en", fifo_rd_en, m_in && !m_acc && cyc == m_tstart);
    chk("model_out_valid", out_valid, m_in && !m_acc && cyc >= m_tstart + 2);
    chk("model_busy", busy, !(!m_in || (m_acc && cyc >= m_tacc + m_gap)));
    chk("model_rd_count", rd_count, m_cnt);
    chk("model_out_data", out_data, m_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rd();
    int k = 0;
    do begin tick(1); k++; end while (fifo_rd_en !== 1'b1 && k < 40);
    chk("wait_rd_pulse", fifo_rd_en, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin tick(1); k++; end while (busy !== 1'b0 && k < 40);
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; out_ready = 1'b0; gap_cfg = '0;
    tick(3);
    chk("reset_rd_count", rd_count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    rst = 1'b0;

    // First word, latency and back-to-back pacing with gap 0
    fifo_empty = 1'b0; out_ready = 1'b1; enable = 1'b1;
    wait_rd();
    tick(1);
    chk("t1_pulse_width", fifo_rd_en, 0);
    chk("t1_valid_not_yet", out_valid, 0);
    tick(1);
    chk("t1_valid_rise", out_valid, 1);
    chk("t1_data_A", out_data, 4'hA);
    tick(1);
    chk("t1_count_1", rd_count, 1);
    tick(10);
    enable = 1'b0;
    wait_idle();
    chk("t1_pulses", rd_cyc.size(), 4);
    if (rd_cyc.size() >= 3) begin
      chk("t1_spacing_a", rd_cyc[1] - rd_cyc[0], 4);
      chk("t1_spacing_b", rd_cyc[2] - rd_cyc[1], 4);
    end
    chk("t1_count_4", rd_count, 4);

    // Backpressure in HOLD
    out_ready = 1'b0; enable = 1'b1;
    wait_rd();
    enable = 1'b0;
    tick(2);
    chk("t2_valid", out_valid, 1);
    chk("t2_data_E", out_data, 4'hE);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, 4'hE);
      chk("t2_no_rd", fifo_rd_en, 0);
    end
    out_ready = 1'b1;
    tick(1);
    chk("t2_count_5", rd_count, 5);
    chk("t2_valid_drop", out_valid, 0);
    wait_idle();

    // Gap of 3, gap_cfg changed mid-GAP, enable dropped during CAPTURE
    base = rd_cyc.size();
    gap_cfg = 4'd3; enable = 1'b1;
    wait_rd();
    tick(4);
    gap_cfg = '0;
    tick(8);
    enable = 1'b0;
    wait_idle();
    chk("t3_pulses", rd_cyc.size() - base, 3);
    if (rd_cyc.size() >= base + 3) begin
      chk("t3_spacing_gap3", rd_cyc[base+1] - rd_cyc[base], 7);
      chk("t3_spacing_gap0", rd_cyc[base+2] - rd_cyc[base+1], 4);
    end
    chk("t3_count_8", rd_count, 8);

    // Empty FIFO holds off reads; empty seen outside IDLE is ignored
    fifo_empty = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t4_no_rd", fifo_rd_en, 0);
      chk("t4_not_busy", busy, 0);
    end
    fifo_empty = 1'b0;
    tick(1);
    chk("t4_rd_after_empty", fifo_rd_en, 1);
    enable = 1'b0; fifo_empty = 1'b1;
    wait_idle();
    chk("t4_count_9", rd_count, 9);
    fifo_empty = 1'b0;

    // Reset in HOLD abandons the word
    out_ready = 1'b0; enable = 1'b1;
    wait_rd();
    enable = 1'b0;
    tick(2);
    chk("t5_valid_before", out_valid, 1);
    chk("t5_count_before", rd_count, 9);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid_rst", out_valid, 0);
    chk("t5_data_rst", out_data, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_rd_en_rst", fifo_rd_en, 0);
    chk("t5_count_rst", rd_count, 0);
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;

    // 256 words wrap rd_count; enable dropped during the last CAPTURE
    base = rd_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 256; i++) wait_rd();
    tick(1);
    enable = 1'b0;
    wait_idle();
    chk("t6_count_wrap", rd_count, 0);
    tick(10);
    chk("t6_pulses", rd_cyc.size() - base, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
